// File: rtl/seq_cnt_pkg.sv
// Shared types and default parameters for the sequence-match window counter.
package seq_cnt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } win_state_t;

  localparam int CNT_W_DEF   = 8;
  localparam int WIN_CYC_DEF = 64;
  localparam int THRESH_DEF  = 4;

endpackage

// File: rtl/seq_cnt_out_slot.sv
// One-entry valid/ready result register; a load while full and not draining
// is discarded and latches the sticky dropped flag.
module seq_cnt_out_slot
  import seq_cnt_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_ovf,
  input  logic         load_alarm,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         ovf,
  output logic         alarm,
  output logic         dropped
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= 1'b0;
      data    <= '0;
      ovf     <= 1'b0;
      alarm   <= 1'b0;
      dropped <= 1'b0;
    end else if (load) begin
      // A handshake on the same edge frees the slot for the new result.
      if (!valid || ready) begin
        valid <= 1'b1;
        data  <= load_data;
        ovf   <= load_ovf;
        alarm <= load_alarm;
      end else begin
        dropped <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_match_window_counter.sv
// Counts detector match pulses over fixed windows of WIN_CYC cycles and hands
// each window's count to a valid/ready slot. Define SEQ_CNT_SATURATE_EN to
// make the match counter saturate instead of wrapping.
//
//   state | meaning
//   IDLE  | en low; match_in ignored, counters held at zero
//   RUN   | sampling; window closes when win_cnt reaches WIN_CYC-1
module seq_match_window_counter
  import seq_cnt_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int WIN_CYC = WIN_CYC_DEF,
  parameter int THRESH  = THRESH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             match_in,
  input  logic             cnt_ready,
  output logic             cnt_valid,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_ovf,
  output logic             alarm,
  output logic             dropped
);

  localparam int          WIN_W    = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
  localparam logic [31:0] THRESH_U = THRESH;

  win_state_t       state;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] match_cnt;
  logic             ovf_acc;

  logic             last;
  logic             at_max;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] res_cnt;
  logic             res_ovf;
  logic             res_alarm;
  logic             load;

`ifdef SEQ_CNT_SATURATE_EN
  assign cnt_inc = at_max ? match_cnt : match_cnt + 1'b1;
`else
  assign cnt_inc = match_cnt + 1'b1;
`endif

  always_comb begin
    last      = (win_cnt == WIN_W'(WIN_CYC - 1));
    at_max    = (match_cnt == {CNT_W{1'b1}});
    res_cnt   = match_in ? cnt_inc : match_cnt;
    res_ovf   = ovf_acc | (match_in & at_max);
    res_alarm = (32'(res_cnt) >= THRESH_U);
    load      = (state == RUN) && en && last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      win_cnt   <= '0;
      match_cnt <= '0;
      ovf_acc   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          win_cnt   <= '0;
          match_cnt <= '0;
          ovf_acc   <= 1'b0;
          if (en) state <= RUN;
        end
        RUN: begin
          if (!en || last) begin
            // Dropping en discards the partial window; a closing window
            // restarts with no gap cycle.
            if (!en) state <= IDLE;
            win_cnt   <= '0;
            match_cnt <= '0;
            ovf_acc   <= 1'b0;
          end else begin
            win_cnt   <= win_cnt + 1'b1;
            match_cnt <= res_cnt;
            ovf_acc   <= res_ovf;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  seq_cnt_out_slot #(
    .W(CNT_W)
  ) u_slot (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_data  (res_cnt),
    .load_ovf   (res_ovf),
    .load_alarm (res_alarm),
    .ready      (cnt_ready),
    .valid      (cnt_valid),
    .data       (cnt_data),
    .ovf        (cnt_ovf),
    .alarm      (alarm),
    .dropped    (dropped)
  );

endmodule
